// File: rtl/bist_mem_responder.sv
// bist_mem_responder
//   Memory-side responder for the BIST memory port. It holds NUM_BANKS banks of
//   2**ADDR_W words x DATA_W bits, one read-output latch per bank and a
//   registered read-data mux. It also flags protocol violations and keeps
//   saturating write/read access counters.
//
// Ports
//   CLK, RSTN          clock, asynchronous active-low reset
//   MEM_ADDR           word address within the selected bank
//   MEM_CE             access enable (active high)
//   MEM_WEB            0 = write, 1 = read
//   MEM_CSB            per-bank chip select, one-hot-low
//   MEM_OEB            per-bank output enable, one-hot-low
//   MEM_IDATA          write data
//   MEM_ODATA_SELECT   bank whose latch drives MEM_ODATA
//   MEM_ODATA          registered read data (read latency = 2 edges)
//   PROT_ERR           sticky protocol-violation flag
//   WR_CNT, RD_CNT     saturating committed write/read counts
//   ERR_CLR            synchronous clear of PROT_ERR and both counters
//
// Optional build macro: BIST_MEM_STUCK_FAULT_EN
//   Adds FAULT_ARM/FAULT_BANK/FAULT_ADDR/FAULT_BIT/FAULT_VAL. While armed, a
//   read of the matching word loads the latch with one bit forced. Stored
//   data is never modified.

module bist_mem_responder #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int NUM_BANKS = 64,
  parameter int CNT_W     = 16
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic [ADDR_W-1:0]    MEM_ADDR,
  input  logic                 MEM_CE,
  input  logic                 MEM_WEB,
  input  logic [NUM_BANKS-1:0] MEM_CSB,
  input  logic [NUM_BANKS-1:0] MEM_OEB,
  input  logic [DATA_W-1:0]    MEM_IDATA,
  input  logic [5:0]           MEM_ODATA_SELECT,
  output logic [DATA_W-1:0]    MEM_ODATA,
  output logic                 PROT_ERR,
  output logic [CNT_W-1:0]     WR_CNT,
  output logic [CNT_W-1:0]     RD_CNT,
`ifdef BIST_MEM_STUCK_FAULT_EN
  input  logic                 FAULT_ARM,
  input  logic [5:0]           FAULT_BANK,
  input  logic [ADDR_W-1:0]    FAULT_ADDR,
  input  logic [2:0]           FAULT_BIT,
  input  logic                 FAULT_VAL,
`endif
  input  logic                 ERR_CLR
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int DEPTH  = NUM_BANKS * (2 ** ADDR_W);

  // Array contents are intentionally not reset.
  logic [DATA_W-1:0] mem_q   [DEPTH];
  logic [DATA_W-1:0] latch_q [NUM_BANKS];

  logic [DATA_W-1:0] odata_q,  odata_d;
  logic              err_q,    err_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;

  logic [NUM_BANKS-1:0]     csb_low;
  logic [BANK_W-1:0]        bank;
  logic                     sel_one;
  logic                     oeb_viol;
  logic                     csel_viol;
  logic                     acc_ok;
  logic                     wr_en;
  logic                     rd_en;
  logic [BANK_W+ADDR_W-1:0] mem_idx;
  logic [DATA_W-1:0]        rd_word;

  // Access decode
  always_comb begin
    csb_low = ~MEM_CSB;
    sel_one = $onehot(csb_low);
    bank    = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (csb_low[i]) bank = BANK_W'(i);
    end
    // An output enable without its chip select is illegal even when idle.
    oeb_viol  = |(~MEM_OEB & MEM_CSB);
    csel_viol = MEM_CE && !sel_one;
    // Any violation in the cycle suppresses the access entirely.
    acc_ok    = MEM_CE && sel_one && !oeb_viol;
    wr_en     = acc_ok && !MEM_WEB;
    rd_en     = acc_ok && MEM_WEB && !MEM_OEB[bank];
    mem_idx   = {bank, MEM_ADDR};
  end

  // Read word, with optional stuck-bit injection on the latch path only
  always_comb begin
    rd_word = mem_q[mem_idx];
`ifdef BIST_MEM_STUCK_FAULT_EN
    if (FAULT_ARM && (int'(FAULT_BANK) == int'(bank)) && (FAULT_ADDR == MEM_ADDR)) begin
      rd_word[FAULT_BIT] = FAULT_VAL;
    end
`endif
  end

  // Next-state for output mux, flag and counters
  always_comb begin
    odata_d = '0;
    if (int'(MEM_ODATA_SELECT) < NUM_BANKS) begin
      odata_d = latch_q[MEM_ODATA_SELECT];
    end

    err_d    = err_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (ERR_CLR) begin
      // Clear wins over any same-cycle access or violation.
      err_d    = 1'b0;
      wr_cnt_d = '0;
      rd_cnt_d = '0;
    end else begin
      if (oeb_viol || csel_viol) err_d = 1'b1;
      if (wr_en && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + 1'b1;
      if (rd_en && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + 1'b1;
    end
  end

  // Bank array: writes commit at the edge, so a read on the next edge sees them.
  always_ff @(posedge CLK) begin
    if (wr_en) mem_q[mem_idx] <= MEM_IDATA;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < NUM_BANKS; i++) latch_q[i] <= '0;
    end else if (rd_en) begin
      latch_q[bank] <= rd_word;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      odata_q  <= '0;
      err_q    <= 1'b0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      odata_q  <= odata_d;
      err_q    <= err_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign MEM_ODATA = odata_q;
  assign PROT_ERR  = err_q;
  assign WR_CNT    = wr_cnt_q;
  assign RD_CNT    = rd_cnt_q;

endmodule

// File: tb/tb_bist_mem_responder.sv
module tb_bist_mem_responder;

  logic        CLK;
  logic        RSTN;
  logic [9:0]  MEM_ADDR;
  logic        MEM_CE;
  logic        MEM_WEB;
  logic [63:0] MEM_CSB;
  logic [63:0] MEM_OEB;
  logic [7:0]  MEM_IDATA;
  logic [5:0]  MEM_ODATA_SELECT;
  logic [7:0]  MEM_ODATA;
  logic        PROT_ERR;
  logic [15:0] WR_CNT;
  logic [15:0] RD_CNT;
  logic        ERR_CLR;
`ifdef BIST_MEM_STUCK_FAULT_EN
  logic        FAULT_ARM;
  logic [5:0]  FAULT_BANK;
  logic [9:0]  FAULT_ADDR;
  logic [2:0]  FAULT_BIT;
  logic        FAULT_VAL;
`endif

  int checks;
  int failures;

  bist_mem_responder dut (
    .CLK              (CLK),
    .RSTN             (RSTN),
    .MEM_ADDR         (MEM_ADDR),
    .MEM_CE           (MEM_CE),
    .MEM_WEB          (MEM_WEB),
    .MEM_CSB          (MEM_CSB),
    .MEM_OEB          (MEM_OEB),
    .MEM_IDATA        (MEM_IDATA),
    .MEM_ODATA_SELECT (MEM_ODATA_SELECT),
    .MEM_ODATA        (MEM_ODATA),
    .PROT_ERR         (PROT_ERR),
    .WR_CNT           (WR_CNT),
    .RD_CNT           (RD_CNT),
`ifdef BIST_MEM_STUCK_FAULT_EN
    .FAULT_ARM        (FAULT_ARM),
    .FAULT_BANK       (FAULT_BANK),
    .FAULT_ADDR       (FAULT_ADDR),
    .FAULT_BIT        (FAULT_BIT),
    .FAULT_VAL        (FAULT_VAL),
`endif
    .ERR_CLR          (ERR_CLR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    MEM_CE    = 1'b0;
    MEM_WEB   = 1'b1;
    MEM_CSB   = '1;
    MEM_OEB   = '1;
    MEM_ADDR  = '0;
    MEM_IDATA = '0;
    ERR_CLR   = 1'b0;
  endtask

  task automatic do_write(input int bank, input logic [9:0] addr, input logic [7:0] data);
    MEM_CE    = 1'b1;
    MEM_WEB   = 1'b0;
    MEM_CSB   = ~(64'd1 << bank);
    MEM_OEB   = '1;
    MEM_ADDR  = addr;
    MEM_IDATA = data;
    tick();
    set_idle();
  endtask

  task automatic do_read(input int bank, input logic [9:0] addr);
    MEM_CE   = 1'b1;
    MEM_WEB  = 1'b1;
    MEM_CSB  = ~(64'd1 << bank);
    MEM_OEB  = ~(64'd1 << bank);
    MEM_ADDR = addr;
    tick();
    set_idle();
  endtask

  task automatic test_reset();
    set_idle();
    MEM_ODATA_SELECT = 6'd0;
    RSTN = 1'b0;
    tick();
    tick();
    checks++;
    if (MEM_ODATA !== 8'h00) begin failures++; $display("FAIL reset_odata got=%h exp=00", MEM_ODATA); end
    checks++;
    if (PROT_ERR !== 1'b0) begin failures++; $display("FAIL reset_prot_err got=%b exp=0", PROT_ERR); end
    checks++;
    if (WR_CNT !== 16'h0 || RD_CNT !== 16'h0) begin
      failures++; $display("FAIL reset_counts wr=%h rd=%h exp=0/0", WR_CNT, RD_CNT);
    end
    RSTN = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    MEM_ODATA_SELECT = 6'd5;
    do_write(5, 10'h3A1, 8'hA5);
    do_read(5, 10'h3A1);
    checks++;
    if (MEM_ODATA !== 8'h00) begin failures++; $display("FAIL wr_rd_latency1 got=%h exp=00", MEM_ODATA); end
    tick();
    checks++;
    if (MEM_ODATA !== 8'hA5) begin failures++; $display("FAIL wr_rd_data got=%h exp=a5", MEM_ODATA); end
    checks++;
    if (WR_CNT !== 16'd1 || RD_CNT !== 16'd1) begin
      failures++; $display("FAIL wr_rd_counts wr=%0d rd=%0d exp=1/1", WR_CNT, RD_CNT);
    end
  endtask

  task automatic test_bank_isolation();
    MEM_ODATA_SELECT = 6'd0;
    tick();
    checks++;
    if (MEM_ODATA !== 8'h00) begin failures++; $display("FAIL iso_unread_latch got=%h exp=00", MEM_ODATA); end
    do_write(0, 10'h000, 8'h11);
    do_write(63, 10'h000, 8'h22);
    do_read(0, 10'h000);
    do_read(63, 10'h000);
    MEM_ODATA_SELECT = 6'd0;
    tick();
    checks++;
    if (MEM_ODATA !== 8'h11) begin failures++; $display("FAIL iso_sel0 got=%h exp=11", MEM_ODATA); end
    MEM_ODATA_SELECT = 6'd63;
    #1;
    checks++;
    if (MEM_ODATA !== 8'h11) begin failures++; $display("FAIL iso_lag got=%h exp=11", MEM_ODATA); end
    tick();
    checks++;
    if (MEM_ODATA !== 8'h22) begin failures++; $display("FAIL iso_sel63 got=%h exp=22", MEM_ODATA); end
    MEM_ODATA_SELECT = 6'd0;
    tick();
    checks++;
    if (MEM_ODATA !== 8'h11) begin failures++; $display("FAIL iso_sel0_again got=%h exp=11", MEM_ODATA); end
    checks++;
    if (WR_CNT !== 16'd3 || RD_CNT !== 16'd3) begin
      failures++; $display("FAIL iso_counts wr=%0d rd=%0d exp=3/3", WR_CNT, RD_CNT);
    end
  endtask

  task automatic test_protocol();
    // Two chip selects low with CE: flagged, no write.
    MEM_CE    = 1'b1;
    MEM_WEB   = 1'b0;
    MEM_CSB   = ~64'd3;
    MEM_ADDR  = 10'h000;
    MEM_IDATA = 8'h99;
    tick();
    set_idle();
    checks++;
    if (PROT_ERR !== 1'b1) begin failures++; $display("FAIL multi_csb_err got=%b exp=1", PROT_ERR); end
    checks++;
    if (WR_CNT !== 16'd3) begin failures++; $display("FAIL multi_csb_wrcnt got=%0d exp=3", WR_CNT); end
    MEM_ODATA_SELECT = 6'd0;
    do_read(0, 10'h000);
    tick();
    checks++;
    if (MEM_ODATA !== 8'h11) begin failures++; $display("FAIL multi_csb_nowrite got=%h exp=11", MEM_ODATA); end
    checks++;
    if (PROT_ERR !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", PROT_ERR); end

    ERR_CLR = 1'b1;
    tick();
    set_idle();
    checks++;
    if (PROT_ERR !== 1'b0 || WR_CNT !== 16'd0 || RD_CNT !== 16'd0) begin
      failures++; $display("FAIL err_clr err=%b wr=%0d rd=%0d exp=0/0/0", PROT_ERR, WR_CNT, RD_CNT);
    end

    // Clear in the same cycle as a write: write lands, count discarded.
    MEM_CE    = 1'b1;
    MEM_WEB   = 1'b0;
    MEM_CSB   = ~(64'd1 << 1);
    MEM_ADDR  = 10'h005;
    MEM_IDATA = 8'h5C;
    ERR_CLR   = 1'b1;
    tick();
    set_idle();
    checks++;
    if (WR_CNT !== 16'd0) begin failures++; $display("FAIL clr_wins_wrcnt got=%0d exp=0", WR_CNT); end
    MEM_ODATA_SELECT = 6'd1;
    do_read(1, 10'h005);
    tick();
    checks++;
    if (MEM_ODATA !== 8'h5C) begin failures++; $display("FAIL clr_write_lands got=%h exp=5c", MEM_ODATA); end
    checks++;
    if (RD_CNT !== 16'd1 || WR_CNT !== 16'd0) begin
      failures++; $display("FAIL clr_counts wr=%0d rd=%0d exp=0/1", WR_CNT, RD_CNT);
    end

    // Selected for read but not output-enabled: nothing happens.
    MEM_CE   = 1'b1;
    MEM_WEB  = 1'b1;
    MEM_CSB  = ~(64'd1 << 5);
    MEM_ADDR = 10'h3A1;
    tick();
    set_idle();
    checks++;
    if (PROT_ERR !== 1'b0 || RD_CNT !== 16'd1) begin
      failures++; $display("FAIL no_oeb err=%b rd=%0d exp=0/1", PROT_ERR, RD_CNT);
    end

    // Output enable without chip select, CE low.
    MEM_OEB = ~(64'd1 << 7);
    tick();
    set_idle();
    checks++;
    if (PROT_ERR !== 1'b1) begin failures++; $display("FAIL oeb_no_csb got=%b exp=1", PROT_ERR); end

    ERR_CLR = 1'b1;
    tick();
    set_idle();
    // CE with no chip select at all.
    MEM_CE = 1'b1;
    tick();
    set_idle();
    checks++;
    if (PROT_ERR !== 1'b1) begin failures++; $display("FAIL ce_no_csb got=%b exp=1", PROT_ERR); end
  endtask

  task automatic test_back_to_back();
    MEM_ODATA_SELECT = 6'd2;
    do_write(2, 10'h004, 8'h3C);
    do_read(2, 10'h004);
    tick();
    checks++;
    if (MEM_ODATA !== 8'h3C) begin failures++; $display("FAIL raw_same_addr got=%h exp=3c", MEM_ODATA); end
  endtask

  task automatic test_saturation();
    ERR_CLR = 1'b1;
    tick();
    set_idle();
    MEM_CE  = 1'b1;
    MEM_WEB = 1'b0;
    MEM_CSB = ~(64'd1 << 10);
    for (int i = 0; i < 65534; i++) begin
      MEM_ADDR  = 10'(i);
      MEM_IDATA = 8'(i);
      tick();
    end
    checks++;
    if (WR_CNT !== 16'hFFFE) begin failures++; $display("FAIL sat_below got=%h exp=fffe", WR_CNT); end
    for (int i = 0; i < 6; i++) begin
      tick();
    end
    set_idle();
    checks++;
    if (WR_CNT !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", WR_CNT); end
  endtask

  task automatic test_reset_midstream();
    MEM_ODATA_SELECT = 6'd2;
    do_read(2, 10'h004);
    tick();
    checks++;
    if (MEM_ODATA !== 8'h3C || RD_CNT !== 16'd1) begin
      failures++; $display("FAIL pre_reset odata=%h rd=%0d exp=3c/1", MEM_ODATA, RD_CNT);
    end
    #3;
    RSTN = 1'b0;
    #1;
    checks++;
    if (MEM_ODATA !== 8'h00 || WR_CNT !== 16'h0 || RD_CNT !== 16'h0) begin
      failures++; $display("FAIL async_reset odata=%h wr=%h rd=%h exp=00/0/0", MEM_ODATA, WR_CNT, RD_CNT);
    end
    tick();
    RSTN = 1'b1;
    tick();
    checks++;
    if (MEM_ODATA !== 8'h00) begin failures++; $display("FAIL latch_reset got=%h exp=00", MEM_ODATA); end
    do_read(2, 10'h004);
    tick();
    checks++;
    if (MEM_ODATA !== 8'h3C) begin failures++; $display("FAIL array_kept got=%h exp=3c", MEM_ODATA); end
  endtask

`ifdef BIST_MEM_STUCK_FAULT_EN
  task automatic test_stuck_fault();
    MEM_ODATA_SELECT = 6'd9;
    do_write(9, 10'h010, 8'hFF);
    FAULT_ARM  = 1'b1;
    FAULT_BANK = 6'd9;
    FAULT_ADDR = 10'h010;
    FAULT_BIT  = 3'd3;
    FAULT_VAL  = 1'b0;
    do_read(9, 10'h010);
    FAULT_ARM = 1'b0;
    tick();
    checks++;
    if (MEM_ODATA !== 8'hF7) begin failures++; $display("FAIL fault_armed got=%h exp=f7", MEM_ODATA); end
    do_read(9, 10'h010);
    tick();
    checks++;
    if (MEM_ODATA !== 8'hFF) begin failures++; $display("FAIL fault_disarmed got=%h exp=ff", MEM_ODATA); end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    RSTN     = 1'b1;
    MEM_ODATA_SELECT = 6'd0;
    set_idle();
`ifdef BIST_MEM_STUCK_FAULT_EN
    FAULT_ARM  = 1'b0;
    FAULT_BANK = 6'd0;
    FAULT_ADDR = 10'h000;
    FAULT_BIT  = 3'd0;
    FAULT_VAL  = 1'b0;
`endif
    test_reset();
    test_write_read();
    test_bank_isolation();
    test_protocol();
    test_back_to_back();
    test_saturation();
    test_reset_midstream();
`ifdef BIST_MEM_STUCK_FAULT_EN
    test_stuck_fault();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
